rcp_hdr_extractor: RTL

- Parametrised next-generation RCP header parser for the NetFPGA user data path.
- Tracks packet framing itself from in_wr/in_ctrl using an internal word counter, so no upstream per-word strobes are needed.
- Captures the IOQ and RCP fields at parametrised word offsets and qualifies each packet as RCP or non-RCP.
- Pushes one metadata record per packet into a small FIFO with a valid/ready handshake for the downstream rate-computation stage.

---
 rtl/rcp_pkg.sv | 31 +++
 rtl/rcp_meta_fifo.sv | 61 ++++++
 rtl/rcp_hdr_extractor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rcp_pkg.sv
// Shared constants and the metadata record layout for the RCP header parser.
package rcp_pkg;

  localparam logic [7:0] RCP_TYPE_DEF   = 8'hFE;
  localparam logic [7:0] IOQ_CTRL_DEF   = 8'hFF;

  localparam int PROTO_WORD_DEF = 2;
  localparam int FRATE_WORD_DEF = 4;
  localparam int RTT_WORD_DEF   = 5;

  // Bit positions inside the 64-bit pipeline word
  localparam int PORT_LSB   = 48;
  localparam int LEN_LSB    = 0;
  localparam int PROTO_LSB  = 0;
  localparam int FRATE_LSB  = 16;
  localparam int RTT_LSB    = 32;
  localparam int RPROTO_LSB = 24;

  typedef struct packed {
    logic        is_rcp;
    logic        trunc;
    logic [15:0] out_port;
    logic [15:0] pkt_len;
    logic [31:0] frate;
    logic [15:0] rtt;
    logic [7:0]  proto;
  } meta_t;

  localparam int META_W = $bits(meta_t);

endpackage

// File: rtl/rcp_meta_fifo.sv
// Small synchronous FIFO; head is readable combinationally and reads as zero when empty.
module rcp_meta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees the slot the push lands in, so push-while-full is legal when popping
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/rcp_hdr_extractor.sv
// Tracks packet framing from in_wr/in_ctrl, captures IOQ and RCP fields and
// queues one metadata record per packet for the rate-computation stage.
module rcp_hdr_extractor
  import rcp_pkg::*;
#(
  parameter int             DATA_WIDTH = 64,
  parameter int             CTRL_WIDTH = 8,
  parameter logic [7:0]     IOQ_CTRL   = IOQ_CTRL_DEF,
  parameter int             PROTO_WORD = PROTO_WORD_DEF,
  parameter int             FRATE_WORD = FRATE_WORD_DEF,
  parameter int             RTT_WORD   = RTT_WORD_DEF,
  parameter logic [7:0]     RCP_TYPE   = RCP_TYPE_DEF,
  parameter int             META_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  meta_vld,
  input  logic                  meta_rdy,
  output logic                  meta_is_rcp,
  output logic                  meta_trunc,
  output logic [15:0]           meta_out_port,
  output logic [15:0]           meta_pkt_len,
  output logic [31:0]           meta_frate,
  output logic [15:0]           meta_rtt,
  output logic [7:0]            meta_proto,
  output logic                  meta_drop,
  output logic [15:0]           drop_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MODHDR  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  localparam logic [7:0] PROTO_IDX = 8'(PROTO_WORD);
  localparam logic [7:0] FRATE_IDX = 8'(FRATE_WORD);
  localparam logic [7:0] RTT_IDX   = 8'(RTT_WORD);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] out_port_q, out_port_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic [31:0] frate_q, frate_d;
  logic [15:0] rtt_q, rtt_d;
  logic [7:0]  proto_q, proto_d;
  logic        type_ok_q, type_ok_d;
  logic        rtt_seen_q, rtt_seen_d;
  logic        drop_q, drop_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic        cap_en;
  logic [7:0]  cap_idx;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [$clog2(META_DEPTH):0] fifo_count_unused;
  meta_t       rec_push, head;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_port_d = out_port_q;
    pkt_len_d  = pkt_len_q;
    frate_d    = frate_q;
    rtt_d      = rtt_q;
    proto_d    = proto_q;
    type_ok_d  = type_ok_q;
    rtt_seen_d = rtt_seen_q;
    cap_en     = 1'b0;
    cap_idx    = cnt_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_wr && in_ctrl == CTRL_WIDTH'(IOQ_CTRL)) begin
          out_port_d = in_data[PORT_LSB +: 16];
          pkt_len_d  = in_data[LEN_LSB +: 16];
          frate_d    = '0;
          rtt_d      = '0;
          proto_d    = '0;
          type_ok_d  = 1'b0;
          rtt_seen_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_MODHDR;
        end
      end
      S_MODHDR: begin
        if (in_wr && in_ctrl == '0) begin
          cap_en  = 1'b1;
          cap_idx = 8'd0;
          cnt_d   = 8'd1;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (in_wr) begin
          if (in_ctrl == '0) begin
            cap_en = 1'b1;
            cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end else begin
            // Any control word here ends the packet, including an IOQ word from a lost EOP
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_en) begin
      if (cap_idx == PROTO_IDX) type_ok_d = (in_data[PROTO_LSB +: 8] == RCP_TYPE);
      if (cap_idx == FRATE_IDX) frate_d = in_data[FRATE_LSB +: 32];
      if (cap_idx == RTT_IDX) begin
        rtt_d      = in_data[RTT_LSB +: 16];
        proto_d    = in_data[RPROTO_LSB +: 8];
        rtt_seen_d = 1'b1;
      end
    end
  end

  always_comb begin
    rec_push          = '0;
    rec_push.is_rcp   = type_ok_q & rtt_seen_q;
    rec_push.trunc    = ~rtt_seen_q;
    rec_push.out_port = out_port_q;
    rec_push.pkt_len  = pkt_len_q;
    rec_push.frate    = frate_q;
    rec_push.rtt      = rtt_q;
    rec_push.proto    = proto_q;

    pop          = meta_vld & meta_rdy;
    drop_d       = push & fifo_full & ~pop;
    drop_count_d = (drop_d && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_port_q   <= '0;
      pkt_len_q    <= '0;
      frate_q      <= '0;
      rtt_q        <= '0;
      proto_q      <= '0;
      type_ok_q    <= 1'b0;
      rtt_seen_q   <= 1'b0;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_port_q   <= out_port_d;
      pkt_len_q    <= pkt_len_d;
      frate_q      <= frate_d;
      rtt_q        <= rtt_d;
      proto_q      <= proto_d;
      type_ok_q    <= type_ok_d;
      rtt_seen_q   <= rtt_seen_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  rcp_meta_fifo #(
    .WIDTH (META_W),
    .DEPTH (META_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rec_push),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  assign meta_vld      = ~fifo_empty;
  assign meta_is_rcp   = head.is_rcp;
  assign meta_trunc    = head.trunc;
  assign meta_out_port = head.out_port;
  assign meta_pkt_len  = head.pkt_len;
  assign meta_frate    = head.frate;
  assign meta_rtt      = head.rtt;
  assign meta_proto    = head.proto;
  assign meta_drop     = drop_q;
  assign drop_count    = drop_count_q;

endmodule
